// File: rtl/parallel_adder.sv
// N-bit ripple-carry adder built from full-adder cells, with a registered
// result stage qualified by in_valid/out_valid.

module parallel_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module parallel_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);
  logic [N:0]   c;
  logic [N-1:0] s_w;
  logic         ovf_w;
  logic         zero_w;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_chain
    parallel_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s_w[i]),
      .co (c[i+1])
    );
  end

  // c[N-1] is cin when N == 1, so one expression covers every width
  assign ovf_w  = c[N] ^ c[N-1];
  assign zero_w = (s_w == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s_w;
        cout     <= c[N];
        overflow <= ovf_w;
        zero     <= zero_w;
      end
    end
  end
endmodule

// File: tb/tb_parallel_adder.sv
// Directed-vector bench for parallel_adder at N=8, N=1 and N=16; all
// expected values are hand-computed constants.

module tb_parallel_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        v8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ov8, co8, of8, z8;
  logic [7:0]  s8;

  logic        v1 = 1'b0, c1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        ov1, co1, of1, z1;
  logic [0:0]  s1;

  logic        v16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ov16, co16, of16, z16;
  logic [15:0] s16;

  parallel_adder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .cin(c8),
    .out_valid(ov8), .sum(s8), .cout(co8), .overflow(of8), .zero(z8)
  );

  parallel_adder #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1), .overflow(of1), .zero(z1)
  );

  parallel_adder #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .A(a16), .B(b16), .cin(c16),
    .out_valid(ov16), .sum(s16), .cout(co16), .overflow(of16), .zero(z16)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // observed words are {out_valid, cout, overflow, zero, sum}
  function automatic logic [11:0] obs8();
    return {ov8, co8, of8, z8, s8};
  endfunction

  function automatic logic [4:0] obs1();
    return {ov1, co1, of1, z1, s1};
  endfunction

  function automatic logic [19:0] obs16();
    return {ov16, co16, of16, z16, s16};
  endfunction

  // called on a falling edge; returns on the next falling edge
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [11:0] exp);
    a8 = a; b8 = b; c8 = ci; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    check(tag, obs8(), exp);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [19:0] exp);
    a16 = a; b16 = b; c16 = ci; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    check(tag, obs16(), exp);
  endtask

  logic [7:0]  st_a [4] = '{8'h12, 8'hC8, 8'h9C, 8'h40};
  logic [7:0]  st_b [4] = '{8'h34, 8'h64, 8'h63, 8'h40};
  logic        st_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [11:0] st_e [4] = '{12'h846, 12'hC2C, 12'hD00, 12'hA80};

  // {cout, overflow, zero, sum} for index {A, B, cin}
  logic [3:0]  tbl1 [8] = '{4'h2, 4'h5, 4'h1, 4'hA, 4'h1, 4'hA, 4'hE, 4'h9};

  initial begin
    #2;
    check("rst8",  obs8(),  '0);
    check("rst1",  obs1(),  '0);
    check("rst16", obs16(), '0);
    @(negedge clk);
    rst = 1'b0;

    run8("add_55_28",   8'h55, 8'h28, 1'b0, 12'h87D);
    run8("wrap_ff_01",  8'hFF, 8'h01, 1'b0, 12'hD00);
    run8("ovf_7f_cin",  8'h7F, 8'h00, 1'b1, 12'hA80);
    run8("ff_ff_cin",   8'hFF, 8'hFF, 1'b1, 12'hCFF);
    run8("ovf_80_80",   8'h80, 8'h80, 1'b0, 12'hF00);
    @(negedge clk);
    check("idle_hold", obs8(), 12'h700);

    for (int i = 0; i < 4; i++) begin
      a8 = st_a[i]; b8 = st_b[i]; c8 = st_c[i]; v8 = 1'b1;
      @(negedge clk);
      check($sformatf("stream%0d", i), obs8(), st_e[i]);
    end
    v8 = 1'b0;
    @(negedge clk);
    check("stream_drop", obs8(), 12'h280);
    @(negedge clk);
    check("stream_hold", obs8(), 12'h280);

    a8 = 8'h55; b8 = 8'h28; c8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    check("pre_rst", obs8(), 12'h87D);
    a8 = 8'h11; b8 = 8'h22;
    #2 rst = 1'b1;
    #1 check("rst_async", obs8(), '0);
    @(negedge clk);
    check("rst_held", obs8(), '0);
    rst = 1'b0; v8 = 1'b0;
    @(negedge clk);
    check("no_inflight", obs8(), '0);
    run8("resume", 8'h11, 8'h22, 1'b0, 12'h833);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; c1 = idx[0]; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      check($sformatf("n1_%0d", i), obs1(), {1'b1, tbl1[i]});
    end

    run16("n16_wrap",  16'hFFFF, 16'h0001, 1'b0, 20'hD0000);
    run16("n16_ovf",   16'h7FFF, 16'h0001, 1'b0, 20'hA8000);
    run16("n16_mixed", 16'h1234, 16'hABCD, 1'b1, 20'h8BE02);
    run16("n16_negov", 16'h8000, 16'hFFFF, 1'b0, 20'hE7FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/parallel_adder.md
Name: parallel_adder

Overview:
Parameterized N-bit parallel (ripple-carry) adder with a registered result stage. It adds two unsigned N-bit operands plus a carry-in and presents sum, carry-out and status flags one clock after a valid input. It is used as a general arithmetic building block in datapaths that need a clocked adder with a simple valid qualifier.

Parameters:
N, 8, operand and sum width in bits; legal range 1..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high.
in_valid  input  1  qualifies A, B and cin on the current clock edge.
A  input  N  operand A, unsigned.
B  input  N  operand B, unsigned.
cin  input  1  carry-in into bit 0; tie to 0 for plain A+B.
out_valid  output  1  high for one cycle when sum, cout and the flags hold a new result.
sum  output  N  registered result, (A + B + cin) mod 2^N.
cout  output  1  registered carry out of bit N-1.
overflow  output  1  registered two's-complement overflow flag.
zero  output  1  registered flag; high when sum == 0.

Behaviour:
- Datapath: a chain of N full adders. c[0] = cin; s[i] = A[i]^B[i]^c[i]; c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); cout = c[N]. Build the chain with a generate loop of single-bit full-adder cells, not a behavioural "+".
- overflow = c[N] ^ c[N-1]. For N=1, overflow = c[1] ^ cin.
- zero = (s == 0), computed from the N-bit sum only. cout is ignored for this flag.
- Latency: exactly 1 cycle. When in_valid is high at rising edge k, the registers capture {sum, cout, overflow, zero} at edge k, and out_valid is high during cycle k+1.
- When in_valid is low at an edge: out_valid goes low, and sum, cout, overflow and zero hold their previous values.
- Back-to-back: with in_valid high on consecutive edges, a new result is produced every cycle (throughput 1/cycle). There is no backpressure.
- Reset: while rst is high, sum=0, cout=0, overflow=0, zero=0 and out_valid=0. These values take effect immediately, without waiting for clk.
- If rst is asserted while an operation is in flight, the result is discarded and no out_valid pulse follows.
- After rst deasserts, the first edge with in_valid high produces the first result.
- Wrap-around: a sum of 2^N or more wraps modulo 2^N, with cout=1.
- No X propagation: unqualified input values never reach the outputs.

Test Plan:
- N=8, A=0x55 (85), B=0x28 (40), cin=0, in_valid pulse -> next cycle out_valid=1, sum=0x7D (125), cout=0, overflow=0, zero=0.
- N=8, A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, overflow=0, zero=1; then A=0x7F, B=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
- N=8, A=0xFF, B=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0. Also A=0x80, B=0x80, cin=0 -> sum=0x00, cout=1, overflow=1, zero=1.
- Back-to-back stream of 4 operand pairs with in_valid held high -> 4 consecutive out_valid cycles, each result matching a reference model in order. Then drop in_valid -> out_valid=0 and outputs hold the last result.
- Assert rst mid-stream between clock edges -> outputs and out_valid go to 0 immediately. No out_valid for the in-flight operand. Correct results resume after rst is released.
- Randomized check at N=1, N=8 and N=16 with 1000 vectors -> {cout, sum} == A+B+cin and overflow matches the signed-overflow reference.
